// File: rtl/dcache_axi_bridge.sv
// Data-cache line-fill / write-back to AXI4 (32-bit) master bridge.
// Independent read and write FSMs; reads wait behind same-line write-backs.
module dcache_axi_bridge #(
  parameter int ID_W       = 4,
  parameter int RD_ID      = 0,
  parameter int WR_ID      = 1,
  parameter int LINE_BEATS = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            c_r_req,
  input  logic [31:0]     c_r_addr,
  output logic            c_r_rdy,
  output logic            c_ret_valid,
  output logic            c_ret_last,
  output logic [31:0]     c_r_data,
  input  logic            c_r_data_ready,
  input  logic            c_w_req,
  input  logic [31:0]     c_w_addr,
  output logic            c_w_rdy,
  input  logic            c_w_data_req,
  input  logic [31:0]     c_w_data,
  input  logic [3:0]      c_w_strb,
  input  logic            c_w_last,
  output logic            c_w_data_ready,
  output logic            c_b_valid,
  input  logic            c_b_ready,
  output logic            bus_err,
  output logic [31:0]     araddr,
  output logic [ID_W-1:0] arid,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic            arvalid,
  input  logic            arready,
  input  logic [31:0]     rdata,
  input  logic [ID_W-1:0] rid,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  output logic [31:0]     awaddr,
  output logic [ID_W-1:0] awid,
  output logic [7:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic            awvalid,
  input  logic            awready,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  input  logic [ID_W-1:0] bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready
);

  localparam logic [7:0] LAST_CNT = 8'(LINE_BEATS - 1);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_state_e;

  r_state_e    r_state_q, r_state_d;
  w_state_e    w_state_q, w_state_d;
  logic [31:0] ar_addr_q, ar_addr_d;
  logic [31:0] aw_addr_q, aw_addr_d;
  logic [7:0]  rd_cnt_q, rd_cnt_d;
  logic [7:0]  wr_cnt_q, wr_cnt_d;
  logic        ar_hold_q, ar_hold_d;
  logic        hazard;
  logic        ar_go;
  logic        rd_err;
  logic        wr_err;
  logic        unused_ids;

  assign unused_ids = ^{rid, bid};

  assign araddr  = ar_addr_q;
  assign arid    = ID_W'(RD_ID);
  assign arlen   = LAST_CNT;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign awaddr  = aw_addr_q;
  assign awid    = ID_W'(WR_ID);
  assign awlen   = LAST_CNT;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;

  assign hazard  = (w_state_q != W_IDLE) &&
                   (ar_addr_q[31:6] == aw_addr_q[31:6]);
  assign bus_err = rd_err | wr_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      w_state_q <= W_IDLE;
      ar_addr_q <= '0;
      aw_addr_q <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      ar_hold_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      ar_addr_q <= ar_addr_d;
      aw_addr_q <= aw_addr_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      ar_hold_q <= ar_hold_d;
    end
  end

  // Once AR is presented it is held even if a same-line write appears later.
  always_comb begin
    r_state_d   = r_state_q;
    ar_addr_d   = ar_addr_q;
    rd_cnt_d    = rd_cnt_q;
    ar_hold_d   = ar_hold_q;
    ar_go       = 1'b0;
    arvalid     = 1'b0;
    c_r_rdy     = 1'b0;
    rready      = 1'b0;
    c_ret_valid = 1'b0;
    c_ret_last  = 1'b0;
    c_r_data    = '0;
    rd_err      = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        if (c_r_req) begin
          ar_addr_d = c_r_addr;
          rd_cnt_d  = '0;
          r_state_d = R_AR;
        end
      end
      R_AR: begin
        ar_go   = ar_hold_q || !hazard;
        arvalid = ar_go;
        if (ar_go && arready) begin
          c_r_rdy   = 1'b1;
          ar_hold_d = 1'b0;
          r_state_d = R_DATA;
        end else if (ar_go) begin
          ar_hold_d = 1'b1;
        end
      end
      R_DATA: begin
        rready      = c_r_data_ready;
        c_ret_valid = rvalid;
        c_ret_last  = rlast;
        c_r_data    = rdata;
        if (rvalid && c_r_data_ready) begin
          rd_cnt_d = rd_cnt_q + 8'd1;
          rd_err   = (rresp != 2'b00) ||
                     (rlast != (rd_cnt_q == LAST_CNT));
          if (rlast) r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d      = w_state_q;
    aw_addr_d      = aw_addr_q;
    wr_cnt_d       = wr_cnt_q;
    awvalid        = 1'b0;
    c_w_rdy        = 1'b0;
    wvalid         = 1'b0;
    wdata          = '0;
    wstrb          = '0;
    wlast          = 1'b0;
    c_w_data_ready = 1'b0;
    bready         = 1'b0;
    c_b_valid      = 1'b0;
    wr_err         = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (c_w_req) begin
          aw_addr_d = c_w_addr;
          wr_cnt_d  = '0;
          w_state_d = W_AW;
        end
      end
      W_AW: begin
        awvalid = 1'b1;
        if (awready) begin
          c_w_rdy   = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        wvalid         = c_w_data_req;
        wdata          = c_w_data;
        wstrb          = c_w_strb;
        wlast          = c_w_last;
        c_w_data_ready = wready;
        if (c_w_data_req && wready) begin
          wr_cnt_d = wr_cnt_q + 8'd1;
          if (c_w_last) begin
            wr_err    = (wr_cnt_q != LAST_CNT);
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        bready    = c_b_ready;
        c_b_valid = bvalid;
        if (bvalid && c_b_ready) begin
          wr_err    = (bresp != 2'b00);
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Directed self-checking bench for dcache_axi_bridge.
module tb_dcache_axi_bridge;

  logic        clk, rst;
  logic        c_r_req, c_r_rdy, c_ret_valid, c_ret_last, c_r_data_ready;
  logic [31:0] c_r_addr, c_r_data;
  logic        c_w_req, c_w_rdy, c_w_data_req, c_w_last, c_w_data_ready;
  logic [31:0] c_w_addr, c_w_data;
  logic [3:0]  c_w_strb;
  logic        c_b_valid, c_b_ready, bus_err;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [3:0]  arid, awid, rid, bid, wstrb;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready;
  logic        bvalid, bready;

  int n_tests = 0;
  int n_fail  = 0;

  dcache_axi_bridge dut (
    .clk(clk), .rst(rst),
    .c_r_req(c_r_req), .c_r_addr(c_r_addr), .c_r_rdy(c_r_rdy),
    .c_ret_valid(c_ret_valid), .c_ret_last(c_ret_last),
    .c_r_data(c_r_data), .c_r_data_ready(c_r_data_ready),
    .c_w_req(c_w_req), .c_w_addr(c_w_addr), .c_w_rdy(c_w_rdy),
    .c_w_data_req(c_w_data_req), .c_w_data(c_w_data),
    .c_w_strb(c_w_strb), .c_w_last(c_w_last),
    .c_w_data_ready(c_w_data_ready),
    .c_b_valid(c_b_valid), .c_b_ready(c_b_ready), .bus_err(bus_err),
    .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd_req(input logic [31:0] addr);
    c_r_req  = 1'b1;
    c_r_addr = addr;
    @(negedge clk);
    c_r_req = 1'b0;
    arready = 1'b0;
    #1;
    chk("ar_valid", arvalid, 1);
    chk("ar_rdy_wait", c_r_rdy, 0);
    arready = 1'b1;
    #1;
    chk("ar_rdy_pulse", c_r_rdy, 1);
    chk("ar_addr", araddr, addr);
    chk("ar_len", arlen, 15);
    chk("ar_size", arsize, 2);
    chk("ar_burst", arburst, 1);
    chk("ar_id", arid, 0);
    @(negedge clk);
    arready = 1'b0;
    #1;
    chk("ar_rdy_once", c_r_rdy, 0);
    chk("ar_drop", arvalid, 0);
  endtask

  task automatic rd_data(input int last_idx, input int bad_idx);
    int   errs;
    int   exp_errs;
    logic e;
    errs     = 0;
    exp_errs = 0;
    for (int i = 0; i <= last_idx; i++) begin
      rvalid         = 1'b1;
      rdata          = 32'hA500_0000 + 32'(i);
      rresp          = (i == bad_idx) ? 2'b10 : 2'b00;
      rlast          = (i == last_idx);
      c_r_data_ready = 1'b1;
      e = (i == bad_idx) || (i == last_idx && last_idx != 15);
      #1;
      chk("r_valid", c_ret_valid, 1);
      chk("r_data", c_r_data, 32'hA500_0000 + 32'(i));
      chk("r_last", c_ret_last, (i == last_idx) ? 1 : 0);
      chk("r_ready", rready, 1);
      chk("r_err", bus_err, e);
      if (bus_err) errs++;
      if (e) exp_errs++;
      @(negedge clk);
    end
    #1;
    chk("r_err_count", errs, exp_errs);
    chk("r_idle_ready", rready, 0);
    chk("r_idle_valid", c_ret_valid, 0);
    rvalid         = 1'b0;
    rlast          = 1'b0;
    rresp          = 2'b00;
    c_r_data_ready = 1'b0;
  endtask

  task automatic wr_to_resp(input logic [31:0] addr);
    int beat;
    int cyc;
    c_w_req  = 1'b1;
    c_w_addr = addr;
    @(negedge clk);
    c_w_req      = 1'b0;
    c_w_data_req = 1'b1;
    c_w_data     = 32'h0;
    c_w_strb     = 4'hF;
    c_w_last     = 1'b0;
    wready       = 1'b1;
    awready      = 1'b0;
    #1;
    chk("aw_valid", awvalid, 1);
    chk("aw_rdy_wait", c_w_rdy, 0);
    chk("w_before_aw", wvalid, 0);
    chk("w_rdy_before_aw", c_w_data_ready, 0);
    awready = 1'b1;
    #1;
    chk("aw_rdy_pulse", c_w_rdy, 1);
    chk("aw_addr", awaddr, addr);
    chk("aw_len", awlen, 15);
    chk("aw_size", awsize, 2);
    chk("aw_burst", awburst, 1);
    chk("aw_id", awid, 1);
    @(negedge clk);
    awready = 1'b0;
    beat    = 0;
    cyc     = 0;
    while (beat < 16 && cyc < 64) begin
      c_w_data_req = 1'b1;
      c_w_data     = 32'(beat);
      c_w_last     = (beat == 15);
      wready       = (cyc % 2 == 1);
      #1;
      chk("w_valid", wvalid, 1);
      chk("w_data", wdata, 32'(beat));
      chk("w_strb", wstrb, 4'hF);
      chk("w_last", wlast, (beat == 15) ? 1 : 0);
      chk("w_ready", c_w_data_ready, (cyc % 2 == 1) ? 1 : 0);
      chk("w_err", bus_err, 0);
      if (wready) beat++;
      cyc++;
      @(negedge clk);
    end
    chk("w_beats", beat, 16);
    c_w_data_req = 1'b0;
    c_w_last     = 1'b0;
    wready       = 1'b0;
  endtask

  task automatic b_resp(input logic [1:0] resp);
    c_b_ready = 1'b1;
    bvalid    = 1'b0;
    #1;
    chk("b_valid_wait", c_b_valid, 0);
    chk("b_ready", bready, 1);
    @(negedge clk);
    bvalid = 1'b1;
    bresp  = resp;
    #1;
    chk("b_valid", c_b_valid, 1);
    chk("b_err", bus_err, (resp != 2'b00) ? 1 : 0);
    @(negedge clk);
    bvalid = 1'b0;
    bresp  = 2'b00;
    #1;
    chk("b_idle_ready", bready, 0);
    chk("b_idle_aw", awvalid, 0);
    c_b_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    c_r_req = 0; c_r_addr = 0; c_r_data_ready = 0;
    c_w_req = 0; c_w_addr = 0; c_w_data_req = 0; c_w_data = 0;
    c_w_strb = 0; c_w_last = 0; c_b_ready = 0;
    arready = 0; rdata = 0; rid = 0; rresp = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_awaddr", awaddr, 0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_arvalid", arvalid, 0);
    chk("idle_awvalid", awvalid, 0);
    chk("idle_rready", rready, 0);
    chk("idle_wvalid", wvalid, 0);
    chk("idle_bready", bready, 0);
    chk("idle_rrdy", c_r_rdy, 0);
    chk("idle_wrdy", c_w_rdy, 0);
    chk("idle_err", bus_err, 0);

    // Plain line read.
    rd_req(32'h0000_1040);
    rd_data(15, -1);

    // Write-back with throttled wready.
    wr_to_resp(32'h0000_2000);
    b_resp(2'b00);

    // Same-line read held until the cycle after B.
    wr_to_resp(32'h0000_3000);
    c_r_req  = 1'b1;
    c_r_addr = 32'h0000_3000;
    @(negedge clk);
    c_r_req = 1'b0;
    arready = 1'b1;
    #1;
    chk("haz_hold0", arvalid, 0);
    chk("haz_rrdy0", c_r_rdy, 0);
    @(negedge clk);
    #1;
    chk("haz_hold1", arvalid, 0);
    c_b_ready = 1'b1;
    bvalid    = 1'b1;
    #1;
    chk("haz_bvalid", c_b_valid, 1);
    chk("haz_hold_bhs", arvalid, 0);
    @(negedge clk);
    bvalid    = 1'b0;
    c_b_ready = 1'b0;
    #1;
    chk("haz_release", arvalid, 1);
    chk("haz_rrdy", c_r_rdy, 1);
    chk("haz_araddr", araddr, 32'h0000_3000);
    @(negedge clk);
    arready = 1'b0;
    rd_data(15, -1);

    // Different line: read proceeds during the write response wait.
    wr_to_resp(32'h0000_3000);
    c_r_req  = 1'b1;
    c_r_addr = 32'h0000_3040;
    @(negedge clk);
    c_r_req = 1'b0;
    #1;
    chk("nohaz_ar", arvalid, 1);
    arready = 1'b1;
    #1;
    chk("nohaz_rrdy", c_r_rdy, 1);
    @(negedge clk);
    arready = 1'b0;
    rd_data(15, -1);
    b_resp(2'b10);

    // Early rlast, then a SLVERR beat.
    rd_req(32'h0000_4000);
    rd_data(7, -1);
    rd_req(32'h0000_4040);
    rd_data(15, 3);

    // Reset in the middle of a read burst with a write waiting on AW.
    c_w_req  = 1'b1;
    c_w_addr = 32'h0000_5000;
    @(negedge clk);
    c_w_req = 1'b0;
    #1;
    chk("rstmid_aw", awvalid, 1);
    rd_req(32'h0000_6000);
    for (int i = 0; i < 5; i++) begin
      rvalid         = 1'b1;
      rdata          = 32'h0000_0600 + 32'(i);
      rlast          = 1'b0;
      c_r_data_ready = 1'b1;
      @(negedge clk);
    end
    rvalid = 1'b1;
    rdata  = 32'h0000_0605;
    #1;
    chk("rstmid_pre", c_ret_valid, 1);
    rst = 1'b1;
    #1;
    chk("rstmid_rvalid", c_ret_valid, 0);
    chk("rstmid_rready", rready, 0);
    chk("rstmid_awvalid", awvalid, 0);
    chk("rstmid_arvalid", arvalid, 0);
    chk("rstmid_err", bus_err, 0);
    @(negedge clk);
    rst            = 1'b0;
    rvalid         = 1'b0;
    c_r_data_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_aw", awvalid, 0);
    chk("post_rst_ar", arvalid, 0);
    rd_req(32'h0000_7000);
    rd_data(15, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
